// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch -- PC, imem valid/ready requests, instruction FIFO,
// redirect squash of in-flight responses. Optional retired-fetch counter under FETCH_PERF_COUNT_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   output logic [31:0] perf_fetch_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   // Each redirect adds at most DEPTH to drop; 8 bits covers long redirect bursts.
   localparam int DW = 8;

   typedef enum logic {RUN, FLUSH} state_t;
   state_t state_q, state_d;

   logic [31:0]   pc_q, resp_pc_q;
   logic [CW-1:0] out_q, out_upd, cnt_q;
   logic [DW-1:0] drop_q, drop_upd, drop_d;
   logic [PW-1:0] rd_q, wr_q;
   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   fifo_pc    [DEPTH];
   logic [CW:0]   credit_used;
   logic          req_fire, resp_drop, resp_take, push, pop;
   logic          unused_bits;

   assign unused_bits = ^redirect_pc[1:0];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign credit_used    = {1'b0, cnt_q} + {1'b0, out_q};
   assign imem_req_valid = reset_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_drop = imem_resp_valid && (drop_q != '0);
   assign resp_take = imem_resp_valid && (drop_q == '0) && (out_q != '0);
   assign push      = resp_take && !redirect_valid;

   assign if_valid = (cnt_q != '0);
   assign pop      = if_valid && if_ready;
   assign if_instr = if_valid ? fifo_instr[rd_q] : '0;
   assign if_pc    = if_valid ? fifo_pc[rd_q]    : '0;

   assign out_upd  = out_q + CW'(req_fire) - CW'(resp_take);
   assign drop_upd = drop_q - DW'(resp_drop);
   // Everything still in flight at a redirect becomes stale, on top of any earlier squash.
   assign drop_d   = redirect_valid ? drop_upd + DW'(out_upd) : drop_upd;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (redirect_valid && drop_d != '0) state_d = FLUSH;
         FLUSH:   if (drop_d == '0) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Requests after a redirect are sequential from the target, and everything issued before
   // it is dropped, so the next surviving response's PC is tracked with a running address.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         out_q     <= '0;
         drop_q    <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (redirect_valid) begin
            pc_q      <= {redirect_pc[31:2], 2'b00};
            resp_pc_q <= {redirect_pc[31:2], 2'b00};
            out_q     <= '0;
         end else begin
            out_q <= out_upd;
            if (req_fire)  pc_q      <= pc_q + 32'd4;
            if (resp_take) resp_pc_q <= resp_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (redirect_valid) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= ptr_inc(wr_q);
         if (pop)  rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: the head is masked by if_valid.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_instr[wr_q] <= imem_resp_data;
         fifo_pc[wr_q]    <= resp_pc_q;
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] perf_q;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  perf_q <= '0;
      else if (pop)  perf_q <= perf_q + 32'd1;
   end
   assign perf_fetch_count = perf_q;
`else
   assign perf_fetch_count = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the RISC-V core; sits directly upstream of the decode/Control block and the register file read.
- Owns the PC register, issues word-aligned requests to instruction memory over a valid/ready interface and buffers returned instructions in a small FIFO.
- Hands instructions and their PC to decode through a valid/ready handshake.
- Handles branch/jump redirects from execute, including squashing responses that are still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, instruction FIFO entries; legal range 2..8.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_addr, output, 32, request address (= PC), always word-aligned.
- imem_req_ready, input, 1, memory accepts request this cycle.
- imem_resp_valid, input, 1, response valid; responses return in order, latency >= 1 cycle.
- imem_resp_data, input, 32, instruction word.
- redirect_valid, input, 1, branch/jump taken; one-cycle pulse.
- redirect_pc, input, 32, new PC; bits [1:0] ignored.
- if_valid, output, 1, instruction available to decode.
- if_instr, output, 32, instruction (FIFO head).
- if_pc, output, 32, PC of if_instr.
- if_ready, input, 1, decode consumes this cycle.
- perf_fetch_count, output, 32, retired-fetch counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - PC=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - Outputs: imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, perf_fetch_count=0.
  - Reset asserted mid-transaction discards all state. Responses arriving after reset release with outstanding=0 are ignored.
- Credit rule:
  - imem_req_valid=1 iff (occupancy + outstanding) < DEPTH and redirect_valid=0.
  - Request fires when imem_req_valid & imem_req_ready. On fire: PC += 4 (mod 2^32; wrap 0xFFFF_FFFC -> 0 is legal) and outstanding++.
  - Each request's PC is pushed to a PC side-queue so the response is paired with its address.
- Response handling:
  - When imem_resp_valid=1 and drop>0: decrement drop, pop the PC side-queue, write nothing to the FIFO.
  - Otherwise: push {data, pc} into the FIFO and decrement outstanding.
  - Overflow is impossible under the credit rule. imem_resp_valid while outstanding=0 is ignored.
- Decode side:
  - if_valid = FIFO non-empty; if_instr/if_pc = head, driven combinationally from registers.
  - Pop on if_valid & if_ready.
  - Push and pop in the same cycle keep occupancy unchanged. This includes a push into a full FIFO in the same cycle as a pop.
- Redirect (redirect_valid=1):
  - Next cycle: PC = {redirect_pc[31:2], 2'b00}; FIFO flushed, occupancy=0.
  - drop = outstanding after this cycle's updates; outstanding=0.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle still counts as consumed.
  - A response arriving in the redirect cycle is dropped.
  - A second redirect while drop>0 adds to drop rather than replacing it.
- Latency: with a 1-cycle memory and if_ready=1, the first instruction appears on if_valid 2 cycles after reset release. Steady throughput is 1 instruction/cycle.
- FSM (fetch control):
  - RUN: normal operation.
  - FLUSH: entered on redirect while drop>0; issues requests but discards stale responses. Returns to RUN when drop reaches 0.
  - imem_req_valid gating is identical in both states.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined: perf_fetch_count increments by 1 on every if_valid & if_ready handshake, wraps at 2^32, resets to 0, and is unaffected by redirect.
- Not defined: perf_fetch_count is tied to 0 and no counter flops are inferred.

Test Plan:
- Reset release, 1-cycle memory returning word = addr, if_ready=1 -> addresses 0,4,8,... issued; if_pc/if_instr 0/0 at cycle 2, then 4/4, 8/8 on consecutive cycles.
- Hold if_ready=0 for 10 cycles -> exactly DEPTH=2 requests issued, imem_req_valid=0 afterwards; release -> pcs 0,4 delivered in order, fetching resumes at 8.
- 3-cycle memory latency, redirect to 0x0000_0103 while 2 requests are outstanding -> both stale responses dropped; next if_pc=0x100, then 0x104; no stale instruction ever reaches if_valid.
- PC starting at 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset_n pulsed low mid-stream with 1 outstanding and the FIFO full -> outputs zero immediately (asynchronously); after release fetch restarts at RESET_PC; the late response is ignored.
- With FETCH_PERF_COUNT_EN defined, 5 handshakes plus 1 redirect -> perf_fetch_count=5; with the macro undefined -> perf_fetch_count stays 0.
